// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller: state encoding,
// floor-index width and timer sizing helpers.
package elevator_pkg;

  localparam logic [2:0] ENC_IDLE       = 3'd0;
  localparam logic [2:0] ENC_MOVE_UP    = 3'd1;
  localparam logic [2:0] ENC_MOVE_DOWN  = 3'd2;
  localparam logic [2:0] ENC_DOOR_OPEN  = 3'd3;
  localparam logic [2:0] ENC_DOOR_CLOSE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE       = ENC_IDLE,
    ST_MOVE_UP    = ENC_MOVE_UP,
    ST_MOVE_DOWN  = ENC_MOVE_DOWN,
    ST_DOOR_OPEN  = ENC_DOOR_OPEN,
    ST_DOOR_CLOSE = ENC_DOOR_CLOSE
  } state_t;

  // Width of a floor index: never narrower than one bit.
  function automatic int floor_width(input int num_floors);
    int w;
    w = $clog2(num_floors);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/elevator_ctrl_if.sv
// Request/status bundle between the car controller (slave) and its
// environment (master: call panels, door sensor, motor and door drives).
interface elevator_ctrl_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8
);
  localparam int FW = floor_width(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] call_req;
  logic                  door_hold;
  logic                  motor_up;
  logic                  motor_down;
  logic                  open_door;
  logic                  close_door;
  logic [FW-1:0]         current_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;

  modport master (
    output call_req, door_hold,
    input  motor_up, motor_down, open_door, close_door,
           current_floor, pending, dir_up
  );

  modport slave (
    input  call_req, door_hold,
    output motor_up, motor_down, open_door, close_door,
           current_floor, pending, dir_up
  );

endinterface

// File: rtl/elevator_req_reg.sv
// Latched floor-request bitmap with position queries relative to the car:
// request at the current floor, any request above, any request below.
module elevator_req_reg
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FW         = floor_width(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] i_set,
  input  logic [NUM_FLOORS-1:0] i_clr,
  input  logic [FW-1:0]         i_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_at_floor,
  output logic                  o_any_above,
  output logic                  o_any_below
);

  logic [NUM_FLOORS-1:0] r_pending;
  logic                  w_any_above;
  logic                  w_any_below;

  // NOTE: asynchronous active-low reset; sequential state is only ever
  // written with non-blocking assignments so every flop samples the same
  // pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      // Clear wins over a same-edge set for the floor being served.
      r_pending <= (r_pending | i_set) & ~i_clr;
    end
  end

  // NOTE: defaults first so every path assigns the flags and no latch forms.
  always_comb begin
    w_any_above = 1'b0;
    w_any_below = 1'b0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (r_pending[f] && (f > int'(i_floor))) w_any_above = 1'b1;
      if (r_pending[f] && (f < int'(i_floor))) w_any_below = 1'b1;
    end
  end

  assign o_pending   = r_pending;
  assign o_at_floor  = r_pending[i_floor];
  assign o_any_above = w_any_above;
  assign o_any_below = w_any_below;

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car collective-control elevator: serves requests ahead in the travel
// direction, reverses when none remain, and times travel/door phases with
// one shared down-counter.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int MOVE_CYCLES  = 8,
  parameter int DOOR_CYCLES  = 16,
  parameter int CLOSE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  elevator_ctrl_if.slave bus
);

  localparam int FW = floor_width(NUM_FLOORS);
  localparam int CW = $clog2(max3(MOVE_CYCLES, DOOR_CYCLES, CLOSE_CYCLES) + 1);

  localparam logic [CW-1:0]         MOVE_LOAD  = CW'(MOVE_CYCLES - 1);
  localparam logic [CW-1:0]         DOOR_LOAD  = CW'(DOOR_CYCLES - 1);
  localparam logic [CW-1:0]         CLOSE_LOAD = CW'(CLOSE_CYCLES - 1);
  localparam logic [FW-1:0]         TOP_FLOOR  = FW'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0   = NUM_FLOORS'(1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [FW-1:0]   r_floor;
  logic            r_dir_up;
  logic            r_motor_up;
  logic            r_motor_down;
  logic            r_open_door;
  logic            r_close_door;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [FW-1:0]   w_floor_nxt;
  logic            w_dir_nxt;
  logic            w_clr_en;
  logic            w_go_up;

  logic [NUM_FLOORS-1:0] w_pending;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  w_at_floor;
  logic                  w_any_above;
  logic                  w_any_below;
  logic                  w_in_door;
  logic                  w_reopen;
  logic [FW-1:0]         w_floor_up;
  logic [FW-1:0]         w_floor_dn;

  assign w_in_door  = (r_state == ST_DOOR_OPEN) || (r_state == ST_DOOR_CLOSE);
  assign w_reopen   = bus.door_hold || bus.call_req[r_floor];
  assign w_floor_up = r_floor + FW'(1);
  assign w_floor_dn = r_floor - FW'(1);

  // A call for the floor whose door is active extends the door instead of latching.
  assign w_set = bus.call_req & ~(w_in_door ? (ONE_HOT0 << r_floor) : '0);
  assign w_clr = w_clr_en ? (ONE_HOT0 << w_floor_nxt) : '0;

  elevator_req_reg #(
    .NUM_FLOORS (NUM_FLOORS),
    .FW         (FW)
  ) u_req_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set       (w_set),
    .i_clr       (w_clr),
    .i_floor     (r_floor),
    .o_pending   (w_pending),
    .o_at_floor  (w_at_floor),
    .o_any_above (w_any_above),
    .o_any_below (w_any_below)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_floor_nxt = r_floor;
    w_dir_nxt   = r_dir_up;
    w_clr_en    = 1'b0;
    w_go_up     = r_dir_up ? w_any_above : !w_any_below;

    unique case (r_state)
      ST_IDLE: begin
        if (w_at_floor) begin
          w_state_nxt = ST_DOOR_OPEN;
          w_cnt_nxt   = DOOR_LOAD;
          w_clr_en    = 1'b1;
        end else if (w_any_above || w_any_below) begin
          w_dir_nxt   = w_go_up;
          w_state_nxt = w_go_up ? ST_MOVE_UP : ST_MOVE_DOWN;
          w_cnt_nxt   = MOVE_LOAD;
        end
      end

      ST_MOVE_UP: begin
        if (r_floor == TOP_FLOOR) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_floor_nxt = w_floor_up;
          if (w_pending[w_floor_up]) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_cnt_nxt   = DOOR_LOAD;
            w_clr_en    = 1'b1;
          end else begin
            w_cnt_nxt   = MOVE_LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      ST_MOVE_DOWN: begin
        if (r_floor == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_floor_nxt = w_floor_dn;
          if (w_pending[w_floor_dn]) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_cnt_nxt   = DOOR_LOAD;
            w_clr_en    = 1'b1;
          end else begin
            w_cnt_nxt   = MOVE_LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      ST_DOOR_OPEN: begin
        if (w_reopen) begin
          w_cnt_nxt = DOOR_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_DOOR_CLOSE;
          w_cnt_nxt   = CLOSE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      ST_DOOR_CLOSE: begin
        if (w_reopen) begin
          w_state_nxt = ST_DOOR_OPEN;
          w_cnt_nxt   = DOOR_LOAD;
          w_clr_en    = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Drive outputs are registered from the next state so they always equal a
  // decode of the state register without a combinational glitch path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_floor      <= '0;
      r_dir_up     <= 1'b1;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
      r_open_door  <= 1'b0;
      r_close_door <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_floor      <= w_floor_nxt;
      r_dir_up     <= w_dir_nxt;
      r_motor_up   <= (w_state_nxt == ST_MOVE_UP);
      r_motor_down <= (w_state_nxt == ST_MOVE_DOWN);
      r_open_door  <= (w_state_nxt == ST_DOOR_OPEN);
      r_close_door <= (w_state_nxt == ST_DOOR_CLOSE);
    end
  end

  assign bus.motor_up      = r_motor_up;
  assign bus.motor_down    = r_motor_down;
  assign bus.open_door     = r_open_door;
  assign bus.close_door    = r_close_door;
  assign bus.current_floor = r_floor;
  assign bus.pending       = w_pending;
  assign bus.dir_up        = r_dir_up;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench: each request batch pushes its expected service order;
// a monitor pops one entry per door opening and checks safety every cycle.
module tb_elevator_ctrl;

  localparam int NF = 8;
  localparam int MC = 3;
  localparam int DC = 4;
  localparam int CC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elevator_ctrl_if #(.NUM_FLOORS(NF)) bus ();

  elevator_ctrl #(
    .NUM_FLOORS   (NF),
    .MOVE_CYCLES  (MC),
    .DOOR_CYCLES  (DC),
    .CLOSE_CYCLES (CC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int m_floor = 0;
  bit m_dir   = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: collective control from an idle car. The current floor is
  // served first, then every request ahead in travel order, then the rest
  // after one reversal.
  function automatic void plan(input logic [NF-1:0] m);
    int  c;
    int  last;
    bit  behind;
    c      = m_floor;
    last   = c;
    behind = 1'b0;
    if (m[c]) exp_q.push_back(c);
    if (m_dir) begin
      for (int f = c + 1; f < NF; f++) if (m[f]) begin exp_q.push_back(f); last = f; end
      for (int f = c - 1; f >= 0; f--) if (m[f]) begin exp_q.push_back(f); last = f; behind = 1'b1; end
    end else begin
      for (int f = c - 1; f >= 0; f--) if (m[f]) begin exp_q.push_back(f); last = f; end
      for (int f = c + 1; f < NF; f++) if (m[f]) begin exp_q.push_back(f); last = f; behind = 1'b1; end
    end
    if (behind) m_dir = !m_dir;
    m_floor = last;
  endfunction

  bit prev_open = 1'b0;
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      prev_open = 1'b0;
    end else begin
      check("motor_exclusive", int'(bus.motor_up && bus.motor_down), 0);
      check("motor_with_door", int'((bus.motor_up || bus.motor_down) &&
                                    (bus.open_door || bus.close_door)), 0);
      check("door_exclusive", int'(bus.open_door && bus.close_door), 0);
      if (bus.open_door && !prev_open) begin
        if (exp_q.size() == 0) begin
          check("unexpected_stop", int'(bus.current_floor), -1);
        end else begin
          e = exp_q.pop_front();
          check("stop_floor", int'(bus.current_floor), e);
          check("stop_cleared", int'(bus.pending[bus.current_floor]), 0);
        end
      end
      prev_open = bus.open_door;
    end
  end

  // Called at a falling edge; the request is sampled by the next rising edge.
  task automatic pulse(input logic [NF-1:0] m);
    bus.call_req = m;
    @(negedge clk);
    bus.call_req = '0;
  endtask

  // mode 0: no hold; 1: one hold pulse in the first close cycle;
  // 2: random hold while the door is open.
  task automatic run_idle(input int mode, output int up, output int dn,
                          output int op, output int cl, output int first_act);
    bit hold_done;
    bit act;
    hold_done = 1'b0;
    up = 0; dn = 0; op = 0; cl = 0; first_act = -1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (mode == 2 && bus.open_door)                    bus.door_hold = ($urandom_range(0, 4) == 0);
      else if (mode == 1 && !hold_done && bus.close_door) begin bus.door_hold = 1'b1; hold_done = 1'b1; end
      else                                               bus.door_hold = 1'b0;
      up += int'(bus.motor_up);
      dn += int'(bus.motor_down);
      op += int'(bus.open_door);
      cl += int'(bus.close_door);
      act = bus.motor_up || bus.motor_down || bus.open_door || bus.close_door;
      if (act && first_act < 0) first_act = n;
      if (!act && bus.pending == '0) begin
        bus.door_hold = 1'b0;
        return;
      end
    end
    bus.door_hold = 1'b0;
    n_vec++;
    n_err++;
    $display("FAIL idle_timeout: car still busy, pending=%0h", bus.pending);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_motor_up"},   int'(bus.motor_up), 0);
    check({tag, "_motor_down"}, int'(bus.motor_down), 0);
    check({tag, "_open"},       int'(bus.open_door), 0);
    check({tag, "_close"},      int'(bus.close_door), 0);
    check({tag, "_floor"},      int'(bus.current_floor), 0);
    check({tag, "_pending"},    int'(bus.pending), 0);
    check({tag, "_dir_up"},     int'(bus.dir_up), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int up, dn, op, cl, fa;
    logic [NF-1:0] m;

    bus.call_req  = '0;
    bus.door_hold = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_reset");

    // Call at the floor the car idles on: door after two edges, no motion.
    plan(NF'(1));
    pulse(NF'(1));
    check("p0_latched", int'(bus.pending[0]), 1);
    @(negedge clk);
    check("p0_door_open", int'(bus.open_door), 1);
    check("p0_no_motor", int'(bus.motor_up || bus.motor_down), 0);
    run_idle(0, up, dn, op, cl, fa);
    check("p0_motor_cycles", up + dn, 0);
    check("p0_open_rest", op, DC - 1);
    check("p0_close", cl, CC);

    // 0 -> 3: three floors of travel, full door cycle.
    plan(NF'(8));
    pulse(NF'(8));
    run_idle(0, up, dn, op, cl, fa);
    check("up3_latency", fa, 1);
    check("up3_motor_up", up, 3 * MC);
    check("up3_motor_down", dn, 0);
    check("up3_open", op, DC);
    check("up3_close", cl, CC);
    check("up3_floor", int'(bus.current_floor), 3);
    check("up3_dir", int'(bus.dir_up), 1);
    check("up3_pending", int'(bus.pending), 0);

    // Hold during closing reopens for a full door period.
    plan(NF'(1) << 6);
    exp_q.push_back(6);
    pulse(NF'(1) << 6);
    run_idle(1, up, dn, op, cl, fa);
    check("hold_motor_up", up, 3 * MC);
    check("hold_open", op, 2 * DC);
    check("hold_close", cl, 1 + CC);
    check("hold_floor", int'(bus.current_floor), 6);

    // Reset while travelling drops position and requests immediately.
    pulse(NF'(1) << 7);
    for (int n = 0; n < 20 && !bus.motor_up; n++) @(negedge clk);
    check("rst_motor_started", int'(bus.motor_up), 1);
    #2 rst_n = 1'b0;
    #1 check_quiet("mid_reset");
    exp_q.delete();
    m_floor = 0;
    m_dir   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("resume");

    // En-route pickups ahead, then the request behind after reversal.
    exp_q.push_back(2);
    exp_q.push_back(5);
    exp_q.push_back(1);
    pulse(NF'(1) << 5);
    for (int n = 0; n < 100 && !(bus.current_floor == 1 && bus.motor_up); n++) @(negedge clk);
    check("route_at_1", int'(bus.current_floor), 1);
    pulse(NF'(1) << 2);
    for (int n = 0; n < 100 && !(bus.current_floor == 2 && bus.open_door); n++) @(negedge clk);
    check("route_door_2", int'(bus.open_door), 1);
    pulse(NF'(1) << 1);
    run_idle(0, up, dn, op, cl, fa);
    check("route_floor", int'(bus.current_floor), 1);
    check("route_dir", int'(bus.dir_up), 0);
    check("route_drained", exp_q.size(), 0);
    m_floor = 1;
    m_dir   = 1'b0;

    // Random batches issued from idle, random door holds.
    for (int b = 0; b < 30; b++) begin
      m = NF'($urandom_range(1, (1 << NF) - 1));
      if ($urandom_range(0, 3) == 0) m = NF'(1) << $urandom_range(0, NF - 1);
      plan(m);
      pulse(m);
      run_idle(2, up, dn, op, cl, fa);
      check("rand_floor", int'(bus.current_floor), m_floor);
      check("rand_dir", int'(bus.dir_up), int'(m_dir));
      check("rand_drained", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
